// File: rtl/sclk_tone_dcdr_if.sv
// Tone decoder port bundle: the incoming square-wave tone and the decoded
// note result. The tone source / result consumer uses the master view, the
// decoder itself uses the slave view.
interface sclk_tone_dcdr_if;
    logic       sclk_in;   // square-wave tone, asynchronous to clk
    logic [7:0] code;      // 0 = silent, 1..36 = note index, 8'hFF = unmatched
    logic       valid;     // one-cycle pulse whenever code is written
    logic       lock;      // high while the last search found a note

    modport master (
        output sclk_in,
        input  code,
        input  valid,
        input  lock
    );

    modport slave (
        input  sclk_in,
        output code,
        output valid,
        output lock
    );
endinterface

// File: rtl/sclk_tone_dcdr.sv
// Square-wave tone decoder.
// Measures the number of clk cycles between consecutive edges of sclk_in and
// looks the measurement up in a 36-entry table of divider maxcounts, one
// entry per cycle. The first entry within TOL of the measurement wins. A tone
// that stops for TMO cycles is reported once as silent (code 0).
module sclk_tone_dcdr #(
    parameter int unsigned TOL = 16,
    parameter logic [16:0] TMO = 17'h10000
) (
    input  logic             clk,
    input  logic             rst,
    sclk_tone_dcdr_if.slave  tone
);

    typedef enum logic [1:0] {
        ST_WAIT,    // no reference edge yet
        ST_MEAS,    // counting cycles since the last edge
        ST_SEARCH,  // walking the table, one entry per cycle
        ST_DONE     // publish the result for one cycle
    } state_t;

    localparam logic [16:0] TOL_W    = 17'(TOL);
    localparam logic [5:0]  LAST_IDX = 6'd36;

    // Divider maxcount for each note index; index 0 is unused.
    // NOTE: this table is constant combinational logic, not storage, so it
    // has no reset and no write port.
    function automatic logic [15:0] tone_table(input logic [5:0] i);
        case (i)
            6'd1:    return 16'hBAA2;
            6'd2:    return 16'hB029;
            6'd3:    return 16'hA646;
            6'd4:    return 16'h9CF1;
            6'd5:    return 16'h9422;
            6'd6:    return 16'h8BD1;
            6'd7:    return 16'h83F8;
            6'd8:    return 16'h7C90;
            6'd9:    return 16'h7592;
            6'd10:   return 16'h6EF9;
            6'd11:   return 16'h68BF;
            6'd12:   return 16'h62DE;
            6'd13:   return 16'h5D51;
            6'd14:   return 16'h5814;
            6'd15:   return 16'h5323;
            6'd16:   return 16'h4E78;
            6'd17:   return 16'h4A11;
            6'd18:   return 16'h45E9;
            6'd19:   return 16'h41FC;
            6'd20:   return 16'h3E48;
            6'd21:   return 16'h3AC9;
            6'd22:   return 16'h377D;
            6'd23:   return 16'h345F;
            6'd24:   return 16'h316F;
            6'd25:   return 16'h2EA9;
            6'd26:   return 16'h2C0A;
            6'd27:   return 16'h2991;
            6'd28:   return 16'h273C;
            6'd29:   return 16'h2508;
            6'd30:   return 16'h22F4;
            6'd31:   return 16'h20FE;
            6'd32:   return 16'h1F24;
            6'd33:   return 16'h1D65;
            6'd34:   return 16'h1BBE;
            6'd35:   return 16'h1A30;
            6'd36:   return 16'h18B7;
            default: return 16'h0000;
        endcase
    endfunction

    // Synchronizer and edge detect
    logic sync1, sync2, sync_prev;
    logic edge_evt;

    // Interval counter and search datapath
    logic [16:0] cnt;
    logic [16:0] meas, meas_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [7:0]  result, result_nxt;
    logic [16:0] tbl_val;
    logic [16:0] diff;
    logic        hit;

    // FSM
    state_t state, state_nxt;

    // Registered outputs
    logic [7:0] code_q;
    logic       valid_q;
    logic       lock_q;

    // Two-flop synchronizer plus a third flop holding the previous synced level.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= tone.sclk_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // Either polarity of the synchronized tone is an edge event.
    assign edge_evt = sync2 ^ sync_prev;

    // Cycles since the last edge; cleared by an edge, saturating at TMO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (edge_evt) begin
            cnt <= '0;
        end else if (cnt != TMO) begin
            cnt <= cnt + 17'd1;
        end
    end

    // Distance between the measurement and the table entry under test.
    // A measurement above 16 bits can never be a valid divider count.
    assign tbl_val = {1'b0, tone_table(idx)};
    assign diff    = (meas >= tbl_val) ? (meas - tbl_val) : (tbl_val - meas);
    assign hit     = !meas[16] && (diff <= TOL_W);

    // State register and search datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_WAIT;
            meas   <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            meas   <= meas_nxt;
            idx    <= idx_nxt;
            result <= result_nxt;
        end
    end

    // Next-state logic: reference edge, measure, table walk, publish.
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        meas_nxt   = meas;
        idx_nxt    = idx;
        result_nxt = result;

        unique case (state)
            ST_WAIT: begin
                // First edge only establishes the reference point.
                if (edge_evt) begin
                    state_nxt = ST_MEAS;
                end
            end

            ST_MEAS: begin
                // An edge on the timeout cycle still counts as an edge.
                if (edge_evt) begin
                    meas_nxt  = cnt;
                    idx_nxt   = 6'd1;
                    state_nxt = ST_SEARCH;
                end else if (cnt == TMO) begin
                    result_nxt = 8'h00;
                    state_nxt  = ST_DONE;
                end
            end

            ST_SEARCH: begin
                if (edge_evt) begin
                    // A new interval supersedes the one being searched.
                    meas_nxt = cnt;
                    idx_nxt  = 6'd1;
                end else if (hit) begin
                    result_nxt = {2'b00, idx};
                    state_nxt  = ST_DONE;
                end else if (idx == LAST_IDX) begin
                    result_nxt = 8'hFF;
                    state_nxt  = ST_DONE;
                end else begin
                    idx_nxt = idx + 6'd1;
                end
            end

            ST_DONE: begin
                // After silence the next tone needs a fresh reference edge.
                state_nxt = (result == 8'h00) ? ST_WAIT : ST_MEAS;
            end

            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    // Outputs change together on entry to DONE, so VALID and the new CODE
    // appear in the same cycle; CODE and LOCK hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= (state_nxt == ST_DONE);
            if (state_nxt == ST_DONE) begin
                code_q <= result_nxt;
                lock_q <= (result_nxt != 8'h00) && (result_nxt != 8'hFF);
            end
        end
    end

    assign tone.code  = code_q;
    assign tone.valid = valid_q;
    assign tone.lock  = lock_q;

endmodule

// File: tb/tb_sclk_tone_dcdr.sv
// Bench for the tone decoder: directed tone intervals with hand-computed
// latencies and codes, plus an edge-timing model checked every cycle.
module tb_sclk_tone_dcdr;

    localparam int          TOL_I = 16;
    localparam int          TMO_I = 32'h4000;
    localparam logic [16:0] TMO   = 17'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sclk_tone_dcdr_if dut_if ();

    sclk_tone_dcdr #(
        .TOL (TOL_I),
        .TMO (TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tone (dut_if.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int tog_cyc     = 0;
    bit cmp_en      = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] ttab [1:36] = '{
        16'hBAA2, 16'hB029, 16'hA646, 16'h9CF1, 16'h9422, 16'h8BD1,
        16'h83F8, 16'h7C90, 16'h7592, 16'h6EF9, 16'h68BF, 16'h62DE,
        16'h5D51, 16'h5814, 16'h5323, 16'h4E78, 16'h4A11, 16'h45E9,
        16'h41FC, 16'h3E48, 16'h3AC9, 16'h377D, 16'h345F, 16'h316F,
        16'h2EA9, 16'h2C0A, 16'h2991, 16'h273C, 16'h2508, 16'h22F4,
        16'h20FE, 16'h1F24, 16'h1D65, 16'h1BBE, 16'h1A30, 16'h18B7
    };

    // Lowest table index within tolerance of interval m, else 8'hFF.
    function automatic logic [7:0] expect_code(input int m);
        if (m > 65535) return 8'hFF;
        for (int i = 1; i <= 36; i++) begin
            int d;
            d = m - int'(ttab[i]);
            if (d < 0) d = -d;
            if (d <= TOL_I) return 8'(i);
        end
        return 8'hFF;
    endfunction

    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
    logic       m_e = 1'b0;
    int         m_now = 0, m_last = 0, m_due = 0, m_meas = 0;
    bit         m_armed = 1'b0, m_pend = 1'b0, m_done = 1'b0;
    logic [7:0] m_pcode = 8'h00, m_code = 8'h00;
    logic       exp_valid = 1'b0, exp_lock = 1'b0;
    logic [7:0] exp_code = 8'h00;

    // Edge times -> interval -> scheduled result, one step per clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
            m_armed = 1'b0; m_pend = 1'b0;
            exp_valid = 1'b0; exp_code = 8'h00; exp_lock = 1'b0;
        end else begin
            m_now++;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = dut_if.sclk_in;
            m_e  = m_s2 ^ m_s3;
            m_done = m_pend && (m_due == m_now);
            if (m_done) begin
                exp_valid = 1'b1;
                exp_code  = m_pcode;
                exp_lock  = (m_pcode >= 8'd1) && (m_pcode <= 8'd36);
                m_pend    = 1'b0;
                if (m_pcode == 8'h00) m_armed = 1'b0;
            end else begin
                exp_valid = 1'b0;
            end
            if (m_e) begin
                if (!m_done) begin
                    if (!m_armed) begin
                        m_armed = 1'b1;
                    end else begin
                        m_meas  = m_now - m_last - 1;
                        if (m_meas > TMO_I) m_meas = TMO_I;
                        m_code  = expect_code(m_meas);
                        m_pend  = 1'b1;
                        m_pcode = m_code;
                        m_due   = m_now + ((m_code == 8'hFF) ? 37 : int'(m_code) + 1);
                    end
                end
                m_last = m_now;
            end else if (m_armed && !m_pend && !m_done && (m_now - m_last - 1) >= TMO_I) begin
                m_pend  = 1'b1;
                m_pcode = 8'h00;
                m_due   = m_now + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en)
            check("cycle_outputs",
                  {22'd0, dut_if.valid, dut_if.lock, dut_if.code},
                  {22'd0, exp_valid, exp_lock, exp_code});
    end

    // ---------------- directed stimulus ----------------
    task automatic toggle();
        dut_if.sclk_in = ~dut_if.sclk_in;
        tog_cyc = cyc;
    endtask

    task automatic wait_valid(input int budget, output int delta,
                              output logic [7:0] c, output logic l);
        delta = -1; c = 8'h00; l = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dut_if.valid) begin
                delta = cyc - tog_cyc;
                c = dut_if.code;
                l = dut_if.lock;
                return;
            end
        end
    endtask

    // Toggle, expect the result of the interval ending here, then hold
    // the level until gap cycles have passed since the toggle.
    task automatic step(input string name, input int gap, input int exp_delta,
                        input logic [7:0] exp_code_i, input logic exp_lock_i);
        int d; logic [7:0] c; logic l;
        toggle();
        wait_valid(45, d, c, l);
        check({name, "_latency"}, d, exp_delta);
        if (d >= 0 && exp_delta >= 0) begin
            check({name, "_code"}, {24'd0, c}, {24'd0, exp_code_i});
            check({name, "_lock"}, {31'd0, l}, {31'd0, exp_lock_i});
        end
        while (cyc - tog_cyc < gap) @(negedge clk);
    endtask

    initial begin
        int d; logic [7:0] c; logic l;
        dut_if.sclk_in = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_code",  {24'd0, dut_if.code},  32'h0);
        check("reset_valid", {31'd0, dut_if.valid}, 32'h0);
        check("reset_lock",  {31'd0, dut_if.lock},  32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);

        // Highest note: interval 0x18B8 -> M = 0x18B7 -> code 36.
        step("ref0",          6328, -1, 8'h00, 1'b0);
        step("idx36",         6344, 39, 8'h24, 1'b1);
        step("tol_edge_in",   6345, 39, 8'h24, 1'b1);   // M = T[36] + 16
        step("tol_edge_out",  8949, 39, 8'hFF, 1'b0);   // M = T[36] + 17
        step("idx30",         6328, 33, 8'h1E, 1'b1);   // M = 0x22F4

        // Edge 10 cycles into a search: aborted, new M = 9 -> unmatched.
        toggle();
        repeat (10) @(negedge clk);
        toggle();
        wait_valid(60, d, c, l);
        check("abort_latency", d, 39);
        check("abort_code",    {24'd0, c}, 32'hFF);
        check("abort_lock",    {31'd0, l}, 32'h0);

        // Tone stops: one silent report TMO+4 cycles after the last toggle.
        wait_valid(TMO_I + 100, d, c, l);
        check("silence_latency", d, TMO_I + 4);
        check("silence_code",    {24'd0, c}, 32'h0);
        check("silence_lock",    {31'd0, l}, 32'h0);
        wait_valid(500, d, c, l);
        check("silence_once", d, -1);

        // Restart needs two edges.
        step("ref_after_silence",   6328, -1, 8'h00, 1'b0);
        step("idx36_after_silence", 6328, 39, 8'h24, 1'b1);

        // Reset in the middle of a search clears outputs asynchronously.
        toggle();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_code",  {24'd0, dut_if.code},  32'h0);
        check("rst_async_valid", {31'd0, dut_if.valid}, 32'h0);
        check("rst_async_lock",  {31'd0, dut_if.lock},  32'h0);
        @(negedge clk);
        dut_if.sclk_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        step("ref_after_reset",     50, -1, 8'h00, 1'b0);
        step("measure_after_reset", 50, 39, 8'hFF, 1'b0);   // M = 49
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sclk_tone_dcdr.md
SCLK_TONE_DCDR -- requirements
Module: sclk_tone_dcdr

Interface
REQ-001 The block SHALL have one clock, CLK; reset RST SHALL be asynchronous and active-high.
REQ-002 Parameter TOL, default 16: max absolute difference, in CLK cycles, between measured count and a table entry for a match.
REQ-003 Parameter TMO, default 17'h10000: cycles without an edge before the input is declared silent.
REQ-004 CLK  input  1  system clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 SCLK_IN  input  1  square-wave tone, asynchronous to CLK.
REQ-007 CODE  output  8  decoded note code, 0 = silent, 1..36 = table index, 8'hFF = unmatched tone.
REQ-008 VALID  output  1  one-cycle pulse when CODE is written.
REQ-009 LOCK  output  1  high while the last search produced a code in 1..36.

Function
REQ-010 SCLK_IN SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synced value; edge event E = synced value differs from previous (either polarity).
REQ-011 17-bit counter CNT SHALL clear to 0 in the cycle of E and increment by 1 each other cycle, saturating at TMO.
REQ-012 At E, measured value M SHALL be CNT before clearing, i.e. M = cycles between edges minus 1 (equals the divider maxcount that produced the tone).
REQ-013 Table T[1..36] (16-bit hex) SHALL be: BAA2 B029 A646 9CF1 9422 8BD1 83F8 7C90 7592 6EF9 68BF 62DE 5D51 5814 5323 4E78 4A11 45E9 41FC 3E48 3AC9 377D 345F 316F 2EA9 2C0A 2991 273C 2508 22F4 20FE 1F24 1D65 1BBE 1A30 18B7.
REQ-014 FSM states SHALL be: WAIT (no reference edge), MEAS (counting), SEARCH (index I), DONE.
REQ-015 WAIT: on E go to MEAS, no measurement taken (first edge only establishes reference).
REQ-016 MEAS: on E capture M, set I=1, go to SEARCH; if CNT reaches TMO go to DONE with silent result.
REQ-017 SEARCH: one table entry per cycle; if |M - T[I]| <= TOL, result = I, go to DONE; else if I = 36, result = 8'hFF, go to DONE; else I = I+1.
REQ-018 Comparison SHALL be done on 17 bits unsigned; M > 16'hFFFF SHALL never match.
REQ-019 First matching index SHALL win (lowest I) when tolerance windows overlap.
REQ-020 An E during SEARCH SHALL capture a new M and restart at I=1; aborted search SHALL produce no VALID.
REQ-021 DONE (one cycle): CODE <= result, VALID = 1, LOCK = (result in 1..36); then to MEAS, or to WAIT if result was silent.
REQ-022 Latency: match at index k SHALL drive CODE/VALID k+1 cycles after E; no match SHALL drive them 37 cycles after E.
REQ-023 Silent result SHALL set CODE=0, LOCK=0 and pulse VALID exactly once per silence entry; no further VALID until a tone is decoded.
REQ-024 An E in the same cycle as CNT reaching TMO SHALL be treated as E (edge wins).
REQ-025 CODE and LOCK SHALL hold between VALID pulses; VALID SHALL pulse after every completed search, even if CODE is unchanged.

Reset
REQ-026 While RST is high: state WAIT, CNT=0, I=0, M=0, CODE=8'h00, VALID=0, LOCK=0, synchronizer flops 0.
REQ-027 RST asserted mid-SEARCH or mid-MEAS SHALL abort immediately with no VALID; after release the first edge SHALL be reference-only.

Verification
REQ-028 Half-period 0xBAA3 cycles, steady -> after second edge, VALID 2 cycles after E, CODE=1, LOCK=1; repeats every edge.
REQ-029 Half-period 0x18B8 cycles -> CODE=36 (8'h24), LOCK=1, VALID 37 cycles after E.
REQ-030 Half-period 0x9000 cycles (no entry within TOL) -> CODE=8'hFF, LOCK=0, VALID 37 cycles after E.
REQ-031 Tone stopped, SCLK_IN held constant -> after 65536 cycles from last edge, one VALID with CODE=0, LOCK=0; no further VALID; next tone requires two edges.
REQ-032 Edge injected 10 cycles into SEARCH -> no VALID for aborted search; result reflects M=9 (CODE=8'hFF).
REQ-033 RST pulsed mid-SEARCH -> CODE=0, VALID=0, LOCK=0 asynchronously; first post-reset edge yields no VALID.
